lc3_writeback_rf: RTL and testbench
===================================

# lc3_writeback_rf

Parametrised writeback stage for the LC3 core. It selects the result source (ALU, memory, PC), writes it into an N-entry register file, and updates the NZP condition-code register. It serves two asynchronous read ports to decode/execute. It sits between the memory-access stage and the register read ports of decode.

## Interface
Parameters:
- DATA_W, 16, register and datapath width
- NREG, 8, number of general registers (power of two, ≥2)
- AW, $clog2(NREG), register index width (derived; not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- enable_writeback  in  1  write strobe for this cycle
- W_Control  in  3  source select: 0 aluout, 1 memout, 2 pcout, 3–7 illegal
- aluout  in  DATA_W  ALU result
- memout  in  DATA_W  memory read data
- pcout  in  DATA_W  PC-relative result
- dr  in  AW  destination register index
- sr1, sr2  in  AW  source register indices
- VSR1, VSR2  out  DATA_W  source register values
- nzp  out  3  condition codes {N,Z,P}
- wb_done  out  1  one-cycle pulse: a legal write committed on the last edge
- wb_err  out  1  one-cycle pulse: illegal W_Control seen with enable on the last edge

## Operation
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Source mux (combinational) produces DR_in from W_Control. For illegal codes DR_in = 0, and no state changes.
- Legal write: on a rising edge with enable_writeback=1 and W_Control ≤ 2:
  - regs[dr] ← DR_in.
  - nzp ← {DR_in[DATA_W-1], DR_in==0, !DR_in[DATA_W-1] && DR_in!=0}.
  - wb_done ← 1.
- Illegal write: enable_writeback=1 and W_Control ≥ 3.
  - Registers and nzp hold.
  - wb_err ← 1, wb_done ← 0.
- enable_writeback=0: registers, nzp hold; wb_done, wb_err ← 0.
- Reads: VSR1 = regs[sr1], VSR2 = regs[sr2], combinational. sr1 == sr2 is legal, and both ports return the same value.
- Exactly one value is produced per enable; there is no backpressure.

## Timing
- Reset values, applied at the first edge with rst=1:
  - all regs = 0
  - nzp = 3'b010 (Z)
  - wb_done = 0, wb_err = 0
- rst dominates enable_writeback on the same edge; a write presented in the reset cycle is dropped.
- Write latency: data presented in cycle N is visible on VSRx from cycle N+1. nzp and wb_done update at the same edge.
- A write-then-read of the same register in cycle N returns the old value unless bypass is compiled in (see Configuration).
- Back-to-back writes to the same dr: the last one wins. nzp reflects each write in turn.
- nzp always has exactly one bit set.

## Configuration
- LC3_WB_BYPASS_EN defined:
  - When enable_writeback=1, W_Control is legal and srX == dr, VSRX = DR_in in the same cycle (write-through forwarding).
  - Applies to both ports independently.
- Undefined: pure registered read; no forwarding path. Read latency after a write is one cycle.

## Structure
- Shared package lc3_pkg holds:
  - DATA_W default
  - the W_Control encodings WB_SRC_ALU=3'h0, WB_SRC_MEM=3'h1, WB_SRC_PC=3'h2
  - an nzp_of(value) function
- Sub-module lc3_regfile_2r1w: NREG×DATA_W array with sync write, two async reads, and sync reset-to-zero.
- The top level holds the source mux, nzp register, pulse flags and the optional bypass.

## Test plan
- Reset: assert rst 2 cycles → all VSR reads 0, nzp=010, wb_done=0, wb_err=0.
- ALU write: aluout=16'h8001, W_Control=0, dr=3, enable 1 cycle; sr1=3 next cycle → VSR1=8001, nzp=100, wb_done pulses once.
- Zero result: memout=0, W_Control=1, dr=5 → regs[5]=0, nzp=010.
- Positive PC result: pcout=16'h3000, W_Control=2, dr=7 → nzp=001.
- Illegal select: W_Control=5, enable, dr=2 with regs[2]=1234 → regs[2] stays 1234, nzp unchanged, wb_err pulses, wb_done stays 0.
- Bypass and reset race, two checks:
  - Same-cycle read: write aluout=16'h00AA to dr=1 while sr1=sr2=1. With LC3_WB_BYPASS_EN, VSR1=VSR2=00AA in that cycle; without it, both show the old value.
  - Reset race: rst and enable asserted together → the write is dropped and the register reads 0.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC3 writeback definitions: default datapath width, the source-select
// encodings and the condition-code helper.
package lc3_pkg;

  localparam int LC3_DATA_W = 16;

  localparam logic [2:0] WB_SRC_ALU = 3'h0;
  localparam logic [2:0] WB_SRC_MEM = 3'h1;
  localparam logic [2:0] WB_SRC_PC  = 3'h2;

  // {N,Z,P} for a default-width value; exactly one bit is ever set.
  function automatic logic [2:0] nzp_of(input logic [LC3_DATA_W-1:0] value);
    logic neg;
    logic zero;
    neg  = value[LC3_DATA_W-1];
    zero = (value == '0);
    return {neg, zero, !neg && !zero};
  endfunction

endpackage

// File: rtl/lc3_regfile_2r1w.sv
// NREG x DATA_W register file: one synchronous write port, two combinational
// read ports, synchronous clear of every entry on rst.
module lc3_regfile_2r1w #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  // Next-state of every entry: only the addressed one takes the write data.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (we && (waddr == AW'(i))) begin
        regs_d[i] = wdata;
      end
    end
  end

  // Register array with synchronous clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (rst) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign rdata1 = regs_q[raddr1];
  assign rdata2 = regs_q[raddr2];

endmodule

// File: rtl/lc3_writeback_rf.sv
// LC3 writeback stage: source mux, register file write, NZP update and the
// done/error pulses. Optional same-cycle forwarding to the read ports is
// compiled in with the LC3_WB_BYPASS_EN macro.
module lc3_writeback_rf
  import lc3_pkg::*;
#(
  parameter int DATA_W = LC3_DATA_W,
  parameter int NREG   = 8,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_writeback,
  input  logic [2:0]        W_Control,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] memout,
  input  logic [DATA_W-1:0] pcout,
  input  logic [AW-1:0]     dr,
  input  logic [AW-1:0]     sr1,
  input  logic [AW-1:0]     sr2,
  output logic [DATA_W-1:0] VSR1,
  output logic [DATA_W-1:0] VSR2,
  output logic [2:0]        nzp,
  output logic              wb_done,
  output logic              wb_err
);

  logic [DATA_W-1:0] dr_in;
  logic              src_legal;
  logic              commit;
  logic [2:0]        nzp_new;
  logic [2:0]        nzp_d, nzp_q;
  logic              wb_done_d, wb_done_q;
  logic              wb_err_d, wb_err_q;
  logic [DATA_W-1:0] rf_rd1, rf_rd2;

  // Source select; illegal codes produce zero and block the write.
  always_comb begin
    dr_in     = '0;
    src_legal = 1'b0;
    case (W_Control)
      WB_SRC_ALU: begin dr_in = aluout; src_legal = 1'b1; end
      WB_SRC_MEM: begin dr_in = memout; src_legal = 1'b1; end
      WB_SRC_PC:  begin dr_in = pcout;  src_legal = 1'b1; end
      default:    begin dr_in = '0;     src_legal = 1'b0; end
    endcase
  end

  assign commit = enable_writeback && src_legal;

  // The package helper covers the default width; other widths derive inline.
  generate
    if (DATA_W == LC3_DATA_W) begin : g_nzp_pkg
      assign nzp_new = nzp_of(LC3_DATA_W'(dr_in));
    end else begin : g_nzp_gen
      assign nzp_new = {dr_in[DATA_W-1], dr_in == '0,
                        !dr_in[DATA_W-1] && (dr_in != '0)};
    end
  endgenerate

  // Next condition codes and the one-cycle status pulses.
  always_comb begin
    nzp_d     = nzp_q;
    wb_done_d = commit;
    wb_err_d  = enable_writeback && !src_legal;
    if (commit) begin
      nzp_d = nzp_new;
    end
  end

  // Status registers; reset leaves the Z flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      nzp_q     <= 3'b010;
      wb_done_q <= 1'b0;
      wb_err_q  <= 1'b0;
    end else begin
      nzp_q     <= nzp_d;
      wb_done_q <= wb_done_d;
      wb_err_q  <= wb_err_d;
    end
  end

  lc3_regfile_2r1w #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .AW     (AW)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (commit),
    .waddr  (dr),
    .wdata  (dr_in),
    .raddr1 (sr1),
    .raddr2 (sr2),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

`ifdef LC3_WB_BYPASS_EN
  // Write-through: a committing write is visible on a matching port at once.
  assign VSR1 = (commit && (sr1 == dr)) ? dr_in : rf_rd1;
  assign VSR2 = (commit && (sr2 == dr)) ? dr_in : rf_rd2;
`else
  assign VSR1 = rf_rd1;
  assign VSR2 = rf_rd2;
`endif

  assign nzp     = nzp_q;
  assign wb_done = wb_done_q;
  assign wb_err  = wb_err_q;

endmodule

// File: tb/tb_lc3_writeback_rf.sv
// Self-checking bench for lc3_writeback_rf: directed cases followed by random
// traffic, compared against a behavioural model of the register file.
module tb_lc3_writeback_rf;

`ifdef LC3_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable_writeback = 1'b0;
  logic [2:0]  W_Control = 3'd0;
  logic [15:0] aluout = '0;
  logic [15:0] memout = '0;
  logic [15:0] pcout = '0;
  logic [2:0]  dr = '0;
  logic [2:0]  sr1 = '0;
  logic [2:0]  sr2 = '0;
  logic [15:0] VSR1, VSR2;
  logic [2:0]  nzp;
  logic        wb_done, wb_err;

  int total = 0;
  int fails = 0;

  logic [15:0] regs_m [8];
  logic [2:0]  nzp_m;
  logic        done_m, err_m;

  always #5 clk = ~clk;

  lc3_writeback_rf dut (
    .clk              (clk),
    .rst              (rst),
    .enable_writeback (enable_writeback),
    .W_Control        (W_Control),
    .aluout           (aluout),
    .memout           (memout),
    .pcout            (pcout),
    .dr               (dr),
    .sr1              (sr1),
    .sr2              (sr2),
    .VSR1             (VSR1),
    .VSR2             (VSR2),
    .nzp              (nzp),
    .wb_done          (wb_done),
    .wb_err           (wb_err)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model_nzp(input logic [15:0] v);
    if (v == 16'd0) return 3'b010;
    if (int'(v) >= 32768) return 3'b100;
    return 3'b001;
  endfunction

  // Value the chosen source would deliver, or none when the code is illegal.
  function automatic logic [15:0] model_src(input logic [2:0] wc);
    logic [15:0] srcs [3];
    srcs[0] = aluout; srcs[1] = memout; srcs[2] = pcout;
    return (wc <= 3'd2) ? srcs[wc] : 16'd0;
  endfunction

  function automatic logic [15:0] model_read(input logic [2:0] sr);
    if (BYP && enable_writeback && W_Control <= 3'd2 && sr == dr)
      return model_src(W_Control);
    return regs_m[sr];
  endfunction

  // One cycle: drive at negedge, check reads before the edge, apply the
  // model at the edge, then check everything just after it.
  task automatic cycle(input logic r, input logic en, input logic [2:0] wc,
                       input logic [15:0] a, input logic [15:0] m, input logic [15:0] p,
                       input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2);
    @(negedge clk);
    rst = r; enable_writeback = en; W_Control = wc;
    aluout = a; memout = m; pcout = p; dr = d; sr1 = s1; sr2 = s2;
    #1;
    if (!r) begin
      check("pre_vsr1", VSR1, model_read(s1));
      check("pre_vsr2", VSR2, model_read(s2));
    end
    @(posedge clk);
    if (r) begin
      foreach (regs_m[i]) regs_m[i] = 16'd0;
      nzp_m = 3'b010; done_m = 1'b0; err_m = 1'b0;
    end else if (en && wc <= 3'd2) begin
      regs_m[d] = model_src(wc);
      nzp_m = model_nzp(model_src(wc)); done_m = 1'b1; err_m = 1'b0;
    end else begin
      done_m = 1'b0; err_m = en;
    end
    #1;
    check("nzp", {13'd0, nzp}, {13'd0, nzp_m});
    check("wb_done", {15'd0, wb_done}, {15'd0, done_m});
    check("wb_err", {15'd0, wb_err}, {15'd0, err_m});
    if (!r) begin
      check("post_vsr1", VSR1, model_read(s1));
      check("post_vsr2", VSR2, model_read(s2));
    end
  endtask

  initial begin
    foreach (regs_m[i]) regs_m[i] = 16'hxxxx;
    nzp_m = 3'b010; done_m = 1'b0; err_m = 1'b0;

    // Reset for two cycles, then read every register back.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0, 0, 0, 3'(i), 3'(7 - i));

    // ALU write of a negative value, then read it back.
    cycle(0, 1, 3'd0, 16'h8001, 16'h1111, 16'h2222, 3'd3, 3'd0, 3'd0);
    cycle(0, 0, 3'd0, 0, 0, 0, 3'd0, 3'd3, 3'd3);
    check("alu_vsr1", VSR1, 16'h8001);
    check("alu_nzp", {13'd0, nzp}, 16'h0004);
    // Zero memory result and positive PC result.
    cycle(0, 1, 3'd1, 16'h7777, 16'h0000, 16'h5555, 3'd5, 3'd5, 3'd3);
    check("zero_nzp", {13'd0, nzp}, 16'h0002);
    cycle(0, 1, 3'd2, 16'h0000, 16'hFFFF, 16'h3000, 3'd7, 3'd7, 3'd5);
    check("pc_nzp", {13'd0, nzp}, 16'h0001);
    // Illegal select must leave regs[2] and nzp alone.
    cycle(0, 1, 3'd0, 16'h1234, 0, 0, 3'd2, 3'd2, 3'd2);
    cycle(0, 1, 3'd5, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'd2, 3'd2, 3'd2);
    check("illegal_keep", VSR1, 16'h1234);
    check("illegal_err", {15'd0, wb_err}, 16'h0001);
    cycle(0, 0, 3'd0, 0, 0, 0, 3'd0, 3'd2, 3'd2);
    // Same-cycle write/read of register 1 on both ports.
    cycle(0, 1, 3'd0, 16'h00AA, 0, 0, 3'd1, 3'd1, 3'd1);
    // Reset racing a write: the write is dropped.
    cycle(0, 1, 3'd0, 16'h4444, 0, 0, 3'd4, 3'd0, 3'd0);
    cycle(1, 1, 3'd0, 16'h5555, 0, 0, 3'd4, 3'd4, 3'd4);
    cycle(0, 0, 3'd0, 0, 0, 0, 3'd0, 3'd4, 3'd4);
    check("race_vsr", VSR1, 16'h0000);

    // Random traffic, including illegal codes and occasional resets.
    for (int n = 0; n < 300; n++) begin
      cycle(($urandom_range(0, 59) == 0), 1'($urandom), 3'($urandom_range(0, 7)),
            16'($urandom), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom), 16'($urandom),
            3'($urandom), 3'($urandom), 3'($urandom));
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
